// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS-subset control unit.
package cpu_ctrl_pkg;

    localparam int ALUOP_W = 6;
    localparam int STATE_W = 4;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [ALUOP_W-1:0] ALU_PASS_A = 6'h00;
    localparam logic [ALUOP_W-1:0] ALU_ADD    = 6'h20;
    localparam logic [ALUOP_W-1:0] ALU_SUB    = 6'h22;
    localparam logic [ALUOP_W-1:0] ALU_XOR    = 6'h26;
    localparam logic [ALUOP_W-1:0] ALU_SLT    = 6'h2A;

    // Mux select encodings
    localparam logic       MEMIN_ALUR  = 1'b0;
    localparam logic       MEMIN_PC    = 1'b1;
    localparam logic       SRCA_A      = 1'b0;
    localparam logic       SRCA_PC     = 1'b1;
    localparam logic [1:0] SRCB_ONE    = 2'd0;
    localparam logic [1:0] SRCB_B      = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;
    localparam logic [1:0] PCSRC_JUMP  = 2'd0;
    localparam logic [1:0] PCSRC_ALU   = 2'd1;
    localparam logic [1:0] PCSRC_ALUR  = 2'd2;
    localparam logic [1:0] DST_RT      = 2'd0;
    localparam logic [1:0] DST_RD      = 2'd1;
    localparam logic [1:0] DST_R31     = 2'd2;
    localparam logic       REGIN_ALUR  = 1'b0;
    localparam logic       REGIN_MDR   = 1'b1;

    // All 16 encodings are used by running states. The illegal-instruction
    // lockout therefore reuses ST_IDLE, held there by the sticky illegal flag.
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_R_EX     = 4'd3,
        ST_R_WB     = 4'd4,
        ST_I_EX     = 4'd5,
        ST_I_WB     = 4'd6,
        ST_MEM_ADDR = 4'd7,
        ST_MEM_RD   = 4'd8,
        ST_MEM_WB   = 4'd9,
        ST_MEM_WR   = 4'd10,
        ST_BNE_EX   = 4'd11,
        ST_J        = 4'd12,
        ST_JR       = 4'd13,
        ST_JAL_LINK = 4'd14,
        ST_JAL_WB   = 4'd15
    } state_t;

    typedef struct packed {
        logic               pc_we;
        logic               memin;
        logic               mem_we;
        logic               ir_we;
        logic               alu_srca;
        logic [1:0]         alu_srcb;
        logic [ALUOP_W-1:0] aluop;
        logic [1:0]         pc_src;
        logic [1:0]         dst;
        logic               regin;
        logic               reg_we;
        logic               a_we;
        logic               b_we;
        logic               instr_done;
    } ctrl_t;

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational decode of the FSM state into the datapath control vector.
// Only BNE_EX looks at zeroflag; opcode/funct refine the ALU op in the EX states.
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zeroflag,
    output ctrl_t      ctrl
);

    // Per-state control outputs; anything not set stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.memin    = MEMIN_PC;
                ctrl.ir_we    = 1'b1;
                ctrl.alu_srca = SRCA_PC;
                ctrl.alu_srcb = SRCB_ONE;
                ctrl.aluop    = ALU_ADD;
                ctrl.pc_src   = PCSRC_ALU;
                ctrl.pc_we    = 1'b1;
            end
            ST_DECODE: begin
                ctrl.a_we     = 1'b1;
                ctrl.b_we     = 1'b1;
                ctrl.alu_srca = SRCA_PC;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.aluop    = ALU_ADD;
            end
            ST_R_EX: begin
                ctrl.alu_srca = SRCA_A;
                ctrl.alu_srcb = SRCB_B;
                ctrl.aluop    = funct;
            end
            ST_R_WB: begin
                ctrl.dst        = DST_RD;
                ctrl.regin      = REGIN_ALUR;
                ctrl.reg_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_I_EX: begin
                ctrl.alu_srca = SRCA_A;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.aluop    = (opcode == OP_XORI) ? ALU_XOR : ALU_ADD;
            end
            ST_I_WB: begin
                ctrl.dst        = DST_RT;
                ctrl.regin      = REGIN_ALUR;
                ctrl.reg_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_srca = SRCA_A;
                ctrl.alu_srcb = SRCB_IMM;
                ctrl.aluop    = ALU_ADD;
            end
            ST_MEM_RD: begin
                ctrl.memin = MEMIN_ALUR;
            end
            ST_MEM_WB: begin
                ctrl.dst        = DST_RT;
                ctrl.regin      = REGIN_MDR;
                ctrl.reg_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.memin      = MEMIN_ALUR;
                ctrl.mem_we     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_BNE_EX: begin
                ctrl.alu_srca   = SRCA_A;
                ctrl.alu_srcb   = SRCB_B;
                ctrl.aluop      = ALU_SUB;
                ctrl.pc_src     = PCSRC_ALUR;
                ctrl.pc_we      = ~zeroflag;
                ctrl.instr_done = 1'b1;
            end
            ST_J: begin
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_we      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JR: begin
                ctrl.alu_srca   = SRCA_A;
                ctrl.aluop      = ALU_PASS_A;
                ctrl.pc_src     = PCSRC_ALU;
                ctrl.pc_we      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            ST_JAL_LINK: begin
                ctrl.alu_srca = SRCA_PC;
                ctrl.aluop    = ALU_PASS_A;
            end
            ST_JAL_WB: begin
                ctrl.dst        = DST_R31;
                ctrl.regin      = REGIN_ALUR;
                ctrl.reg_we     = 1'b1;
                ctrl.pc_src     = PCSRC_JUMP;
                ctrl.pc_we      = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: state register, next-state logic and
// sticky illegal flag; output decode lives in ctrl_out_decode.
//
//  state     | meaning
//  ----------+------------------------------------------------------------
//  IDLE      | parked, no enables; also the lockout after an illegal instr
//  FETCH     | IR <= mem[PC], PC <= PC+1
//  DECODE    | load A/B, branch target into ALU result reg, dispatch
//  R_EX      | A op B (op from funct)
//  R_WB      | rd <= result (end)
//  I_EX      | A + / ^ sign-extended imm
//  I_WB      | rt <= result (end)
//  MEM_ADDR  | address = A + imm
//  MEM_RD    | memory read, MDR captures
//  MEM_WB    | rt <= MDR (end)
//  MEM_WR    | memory write (end)
//  BNE_EX    | compare A-B, branch if not zero (end)
//  J         | PC <= jump target (end)
//  JR        | PC <= A (end)
//  JAL_LINK  | incremented PC into ALU result reg
//  JAL_WB    | r31 <= link, PC <= jump target (end)
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               zeroflag,
    output logic               PC_WE,
    output logic               MEMIN,
    output logic               MEM_WE,
    output logic               IR_WE,
    output logic               ALU_SRCA,
    output logic [1:0]         ALU_SRCB,
    output logic [ALUOP_W-1:0] ALUOP,
    output logic [1:0]         PC_SRC,
    output logic [1:0]         DST,
    output logic               REGIN,
    output logic               REG_WE,
    output logic               A_WE,
    output logic               B_WE,
    output logic               instr_done,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   set_illegal;
    ctrl_t  ctrl;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Sticky illegal flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           illegal_q <= 1'b0;
        else if (set_illegal) illegal_q <= 1'b1;
    end

    // Next-state logic and opcode dispatch.
    always_comb begin
        state_d     = state_q;
        set_illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en && !illegal_q) state_d = ST_FETCH;
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_ADD || funct == FN_SUB || funct == FN_SLT) begin
                            state_d = ST_R_EX;
                        end else if (funct == FN_JR) begin
                            state_d = ST_JR;
                        end else begin
                            state_d     = ST_IDLE;
                            set_illegal = 1'b1;
                        end
                    end
                    OP_LW, OP_SW:     state_d = ST_MEM_ADDR;
                    OP_ADDI, OP_XORI: state_d = ST_I_EX;
                    OP_BNE:           state_d = ST_BNE_EX;
                    OP_J:             state_d = ST_J;
                    OP_JAL:           state_d = ST_JAL_LINK;
                    default: begin
                        state_d     = ST_IDLE;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ST_R_EX:     state_d = ST_R_WB;
            ST_I_EX:     state_d = ST_I_WB;
            ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD:   state_d = ST_MEM_WB;
            ST_JAL_LINK: state_d = ST_JAL_WB;
            ST_R_WB, ST_I_WB, ST_MEM_WB, ST_MEM_WR,
            ST_BNE_EX, ST_J, ST_JR, ST_JAL_WB: begin
                state_d = en ? ST_FETCH : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    ctrl_out_decode u_decode (
        .state    (state_q),
        .opcode   (opcode),
        .funct    (funct),
        .zeroflag (zeroflag),
        .ctrl     (ctrl)
    );

    // Flatten the control vector onto the ports.
    always_comb begin
        PC_WE      = ctrl.pc_we;
        MEMIN      = ctrl.memin;
        MEM_WE     = ctrl.mem_we;
        IR_WE      = ctrl.ir_we;
        ALU_SRCA   = ctrl.alu_srca;
        ALU_SRCB   = ctrl.alu_srcb;
        ALUOP      = ctrl.aluop;
        PC_SRC     = ctrl.pc_src;
        DST        = ctrl.dst;
        REGIN      = ctrl.regin;
        REG_WE     = ctrl.reg_we;
        A_WE       = ctrl.a_we;
        B_WE       = ctrl.b_we;
        instr_done = ctrl.instr_done;
        illegal    = illegal_q;
        dbg_state  = state_q;
    end

endmodule
